// File: rtl/fsmc_pkg.sv
// Shared types and widths for the FSMC slave-side router.
package fsmc_pkg;

  localparam int unsigned FSMC_DATA_W     = 16;
  localparam int unsigned FSMC_IDX_W      = 3;
  localparam int unsigned FSMC_ADDR_W     = 15;
  localparam int unsigned FSMC_MAX_SLAVES = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERR
  } router_state_t;

  function automatic logic [FSMC_MAX_SLAVES-1:0] idx_onehot(input logic [FSMC_IDX_W-1:0] idx);
    return FSMC_MAX_SLAVES'(1) << idx;
  endfunction

endpackage

// File: rtl/fsmc_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with registered fall/rise pulses
// aligned to the synchronised output.
module fsmc_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall,
  output logic rise
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      dout <= RESET_VAL;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
      fall <= dout & ~meta;
      rise <= ~dout & meta;
    end
  end

endmodule

// File: rtl/fsmc_slave_router.sv
// Shares the FSMC slave port between up to 8 peripherals: decode, read-data return,
// single-cycle rd/wr strobes and a per-access timeout.
module fsmc_slave_router
  import fsmc_pkg::*;
#(
  parameter int unsigned            N_SLAVES = 8,
  parameter int unsigned            TIMEOUT  = 255,
  parameter logic [FSMC_DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en_cs,
  input  logic [FSMC_IDX_W-1:0]           cs_addr_latch,
  input  logic [FSMC_DATA_W-1:0]          module_in,
  input  logic                            noe_n,
  output logic [FSMC_DATA_W-1:0]          module_out,
  output logic                            cs_state,
  input  logic [N_SLAVES-1:0]             cfg_enable,
  output logic [N_SLAVES-1:0]             slave_sel,
  output logic [FSMC_ADDR_W-1:0]          slave_addr,
  output logic [FSMC_DATA_W-1:0]          slave_wdata,
  output logic                            slave_wr_stb,
  output logic                            slave_rd_stb,
  input  logic [FSMC_DATA_W*N_SLAVES-1:0] slave_rdata,
  input  logic                            err_clr,
  output logic                            err_decode,
  output logic                            err_timeout,
  output logic                            busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  router_state_t           state, state_nxt;
  logic                    en_cs_d;
  logic [FSMC_IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    rd_seen, rd_seen_nxt;
  logic [FSMC_DATA_W-1:0]  module_out_nxt, slave_wdata_nxt, rdata_sel;
  logic [FSMC_ADDR_W-1:0]  slave_addr_nxt;
  logic [N_SLAVES-1:0]     slave_sel_nxt;
  logic                    cs_state_nxt, wr_stb_nxt, rd_stb_nxt;
  logic                    err_decode_nxt, err_timeout_nxt;
  logic                    noe_sync, decode_ok, en_rise;
  logic                    noe_fall_unused, noe_rise_unused;

  // Read detection is level-based, so NOE already low at entry still counts.
  fsmc_sync_edge #(.RESET_VAL(1'b1)) u_noe_sync (
    .clk   (clk),
    .reset (reset),
    .din   (noe_n),
    .dout  (noe_sync),
    .fall  (noe_fall_unused),
    .rise  (noe_rise_unused)
  );

  assign en_rise = en_cs & ~en_cs_d;

  always_comb begin
    decode_ok = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++)
      if (cs_addr_latch == FSMC_IDX_W'(i) && cfg_enable[i]) decode_ok = 1'b1;
  end

  always_comb begin
    rdata_sel = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++)
      if (idx == FSMC_IDX_W'(i)) rdata_sel = slave_rdata[FSMC_DATA_W*i +: FSMC_DATA_W];
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cnt_nxt         = cnt;
    rd_seen_nxt     = rd_seen;
    module_out_nxt  = module_out;
    cs_state_nxt    = 1'b0;
    slave_sel_nxt   = '0;
    slave_addr_nxt  = slave_addr;
    slave_wdata_nxt = slave_wdata;
    wr_stb_nxt      = 1'b0;
    rd_stb_nxt      = 1'b0;
    err_decode_nxt  = err_decode & ~err_clr;
    err_timeout_nxt = err_timeout & ~err_clr;

    unique case (state)
      IDLE: begin
        if (en_rise) begin
          idx_nxt        = cs_addr_latch;
          slave_addr_nxt = module_in[FSMC_ADDR_W-1:0];
          if (decode_ok) begin
            state_nxt     = ACTIVE;
            cnt_nxt       = '0;
            rd_seen_nxt   = 1'b0;
            cs_state_nxt  = 1'b1;
            slave_sel_nxt = N_SLAVES'(idx_onehot(cs_addr_latch));
          end else begin
            state_nxt      = ERR;
            err_decode_nxt = 1'b1;
            module_out_nxt = ERR_DATA;
          end
        end
      end
      ACTIVE: begin
        module_out_nxt = rdata_sel;
        if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + 1'b1;
        if (!en_cs) begin
          state_nxt = IDLE;
          if (!rd_seen) begin
            wr_stb_nxt      = 1'b1;
            slave_wdata_nxt = module_in;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt       = ERR;
          err_timeout_nxt = 1'b1;
          module_out_nxt  = ERR_DATA;
        end else begin
          cs_state_nxt  = 1'b1;
          slave_sel_nxt = N_SLAVES'(idx_onehot(idx));
          if (!noe_sync && !rd_seen) begin
            rd_seen_nxt = 1'b1;
            rd_stb_nxt  = 1'b1;
          end
        end
      end
      ERR: begin
        module_out_nxt = ERR_DATA;
        if (!en_cs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      en_cs_d      <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      rd_seen      <= 1'b0;
      module_out   <= '0;
      cs_state     <= 1'b0;
      slave_sel    <= '0;
      slave_addr   <= '0;
      slave_wdata  <= '0;
      slave_wr_stb <= 1'b0;
      slave_rd_stb <= 1'b0;
      err_decode   <= 1'b0;
      err_timeout  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      en_cs_d      <= en_cs;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      rd_seen      <= rd_seen_nxt;
      module_out   <= module_out_nxt;
      cs_state     <= cs_state_nxt;
      slave_sel    <= slave_sel_nxt;
      slave_addr   <= slave_addr_nxt;
      slave_wdata  <= slave_wdata_nxt;
      slave_wr_stb <= wr_stb_nxt;
      slave_rd_stb <= rd_stb_nxt;
      err_decode   <= err_decode_nxt;
      err_timeout  <= err_timeout_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule
